// File: rtl/exmem_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | exmem_pipe : EX/MEM elastic stage register with 2-entry skid buffer,     |
// |              synchronous flush and bubble-safe control outputs.          |
// | Optional   : EXMEM_STATS_EN adds saturating stall/flush counters.        |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
module exmem_pipe #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int REG_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              pcload_E,
  input  logic              regw_E,
  input  logic              memw_E,
  input  logic              regmem_E,
  input  logic [REG_W-1:0]  regScr_E,
  input  logic [DATA_W-1:0] ALUrslt_E,
  input  logic [ADDR_W-1:0] address_E,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              pcload_M,
  output logic              regw_M,
  output logic              memw_M,
  output logic              regmem_M,
  output logic [REG_W-1:0]  regScr_M,
  output logic [DATA_W-1:0] ALUrslt_M,
  output logic [ADDR_W-1:0] address_M
`ifdef EXMEM_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       flush_cnt
`endif
);

  localparam int unsigned c_ENTRY_W = 4 + REG_W + DATA_W + ADDR_W;
  localparam logic [1:0]  c_EMPTY   = 2'd0;
  localparam logic [1:0]  c_ONE     = 2'd1;
  localparam logic [1:0]  c_FULL    = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [c_ENTRY_W-1:0] main_q, main_d;
  logic [c_ENTRY_W-1:0] skid_q, skid_d;
  logic [c_ENTRY_W-1:0] w_entry_in;
  logic                 w_accept, w_consume;
  logic                 w_pc, w_rw, w_mw, w_rm;

  // Handshake flags come from registered state only: no out_ready->in_ready path.
  assign in_ready   = (state_q != c_FULL);
  assign out_valid  = (state_q != c_EMPTY);
  assign w_accept   = in_valid & in_ready;
  assign w_consume  = out_valid & out_ready;
  assign w_entry_in = {pcload_E, regw_E, memw_E, regmem_E, regScr_E, ALUrslt_E, address_E};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      c_EMPTY: begin
        if (w_accept) begin
          state_d = c_ONE;
          main_d  = w_entry_in;
        end
      end
      c_ONE: begin
        if (w_accept && w_consume) begin
          main_d = w_entry_in;
        end else if (w_accept) begin
          state_d = c_FULL;
          skid_d  = w_entry_in;
        end else if (w_consume) begin
          state_d = c_EMPTY;
        end
      end
      c_FULL: begin
        if (w_consume) begin
          state_d = c_ONE;
          main_d  = skid_q;
        end
      end
      default: state_d = c_EMPTY;
    endcase
    // Flush squashes everything and leaves the data registers untouched.
    if (flush) begin
      state_d = c_EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_comb begin
    {w_pc, w_rw, w_mw, w_rm, regScr_M, ALUrslt_M, address_M} = main_q;
    pcload_M = w_pc & out_valid;
    regw_M   = w_rw & out_valid;
    memw_M   = w_mw & out_valid;
    regmem_M = w_rm & out_valid;
  end

`ifdef EXMEM_STATS_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt_q != 32'hFFFF_FFFF)
        stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush && (out_valid || in_valid) && flush_cnt_q != 32'hFFFF_FFFF)
        flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_exmem_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_exmem_pipe : scoreboard bench for exmem_pipe (directed + random).     |
// | Revision      : 1.0                                                      |
// +--------------------------------------------------------------------------+
module tb_exmem_pipe;

  typedef struct packed {
    logic        pcload;
    logic        regw;
    logic        memw;
    logic        regmem;
    logic [3:0]  rs;
    logic [31:0] alu;
    logic [31:0] addr;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        pcload_E = 1'b0, regw_E = 1'b0, memw_E = 1'b0, regmem_E = 1'b0;
  logic [3:0]  regScr_E = '0;
  logic [31:0] ALUrslt_E = '0, address_E = '0;
  logic        in_ready, out_valid;
  logic        pcload_M, regw_M, memw_M, regmem_M;
  logic [3:0]  regScr_M;
  logic [31:0] ALUrslt_M, address_M;
`ifdef EXMEM_STATS_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  exmem_pipe #(.DATA_W(32), .ADDR_W(32), .REG_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .pcload_E(pcload_E), .regw_E(regw_E), .memw_E(memw_E), .regmem_E(regmem_E),
    .regScr_E(regScr_E), .ALUrslt_E(ALUrslt_E), .address_E(address_E),
    .out_valid(out_valid), .out_ready(out_ready),
    .pcload_M(pcload_M), .regw_M(regw_M), .memw_M(memw_M), .regmem_M(regmem_M),
    .regScr_M(regScr_M), .ALUrslt_M(ALUrslt_M), .address_M(address_M)
`ifdef EXMEM_STATS_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: a bounded FIFO of in-flight entries plus the last shown entry.
  ent_t        sb_q[$];
  ent_t        last_main = '0;
  logic        model_ready = 1'b1;
  logic        armed = 1'b0;
  int          tests = 0;
  int          fails = 0;
  int unsigned stall_m = 0, flush_m = 0;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  function automatic ent_t mk(input logic pc, input logic rw, input logic mw, input logic rm,
                              input logic [3:0] rs, input logic [31:0] alu, input logic [31:0] addr);
    ent_t e;
    e.pcload = pc; e.regw = rw; e.memw = mw; e.regmem = rm;
    e.rs = rs; e.alu = alu; e.addr = addr;
    return e;
  endfunction

  // Monitor: samples mid-cycle, before the next rising edge commits the handshake.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      sb_q.delete();
      last_main   = '0;
      model_ready = 1'b1;
      armed       = 1'b1;
      stall_m     = 0;
      flush_m     = 0;
    end else if (armed) begin
      logic exp_v;
      ent_t shown;
      exp_v = (sb_q.size() != 0);
      shown = exp_v ? sb_q[0] : last_main;
      check("out_valid", 72'(out_valid), 72'(exp_v));
      check("in_ready", 72'(in_ready), 72'(sb_q.size() < 2));
      check("data_M", {pcload_M, regw_M, memw_M, regmem_M, regScr_M, ALUrslt_M, address_M},
            {shown.pcload & exp_v, shown.regw & exp_v, shown.memw & exp_v, shown.regmem & exp_v,
             shown.rs, shown.alu, shown.addr});
`ifdef EXMEM_STATS_EN
      check("stall_cnt", 72'(stall_cnt), 72'(stall_m));
      check("flush_cnt", 72'(flush_cnt), 72'(flush_m));
      if (exp_v && !out_ready) stall_m++;
      if (flush && (exp_v || in_valid)) flush_m++;
`endif
      last_main   = shown;
      model_ready = (sb_q.size() < 2);
      if (flush) sb_q.delete();
      else if (exp_v && out_ready) void'(sb_q.pop_front());
    end
  end

  // One cycle of stimulus; the expected entry is queued when the model says it is accepted.
  task automatic drive(input logic v, input ent_t e, input logic ordy, input logic fl, input logic r);
    in_valid = v; out_ready = ordy; flush = fl; rst = r;
    {pcload_E, regw_E, memw_E, regmem_E, regScr_E, ALUrslt_E, address_E} = e;
    @(negedge clk);
    #2;
    if (!r && !fl && v && model_ready) sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  function automatic ent_t rnd();
    ent_t e;
    e.pcload = 1'($urandom); e.regw = 1'($urandom);
    e.memw = 1'($urandom); e.regmem = 1'($urandom);
    e.rs = 4'($urandom); e.alu = $urandom; e.addr = $urandom;
    return e;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t z, ea, eb, ec;
    z = '0;
    // Reset with in_valid held high
    drive(1, mk(1,1,1,1,4'hF,32'hDEAD,32'hBEEF), 0, 0, 1);
    drive(1, mk(1,1,1,1,4'hF,32'hDEAD,32'hBEEF), 0, 0, 1);
    drive(0, z, 1, 0, 0);
    // Streaming
    drive(1, mk(1,1,0,0,4'b0011,32'h0000FFFF,32'h00010004), 1, 0, 0);
    drive(1, mk(0,1,0,0,4'b0100,32'h0000FFFF,32'h0), 1, 0, 0);
    drive(0, z, 1, 0, 0);
    drive(0, z, 1, 0, 0);
    // Backpressure A, B, C
    ea = mk(0,0,0,0,4'd1,32'd1,32'h10);
    eb = mk(0,0,0,0,4'd2,32'd2,32'h20);
    ec = mk(0,0,0,0,4'd3,32'd3,32'h30);
    drive(1, ea, 0, 0, 0);
    drive(1, eb, 0, 0, 0);
    drive(1, ec, 0, 0, 0);
    drive(1, ec, 0, 0, 0);
    drive(1, ec, 1, 0, 0);
    drive(1, ec, 1, 0, 0);
    drive(0, z, 1, 0, 0);
    drive(0, z, 1, 0, 0);
    // Bubble: control outputs drop, data holds
    drive(1, mk(0,1,1,0,4'd7,32'h1234_5678,32'h0000_0040), 1, 0, 0);
    drive(0, z, 1, 0, 0);
    drive(0, z, 1, 0, 0);
    // Flush from FULL with in_valid high, then flush together with reset
    drive(1, rnd(), 0, 0, 0);
    drive(1, rnd(), 0, 0, 0);
    drive(1, rnd(), 0, 1, 0);
    drive(0, z, 0, 0, 0);
    drive(1, rnd(), 0, 0, 0);
    drive(1, rnd(), 0, 1, 1);
    drive(0, z, 1, 0, 0);
    // Stall counting: one entry held for 5 stalled cycles, then flushed from ONE
    drive(1, rnd(), 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, z, 0, 0, 0);
    drive(0, z, 0, 1, 0);
    drive(0, z, 1, 0, 0);
    drive(0, z, 1, 0, 1);
    drive(0, z, 1, 0, 0);
    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 3) != 0), rnd(), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 39) == 0), 1'($urandom_range(0, 99) == 0));
    end
    for (int i = 0; i < 4; i++) drive(0, z, 1, 0, 0);
    check("drain_empty", 72'(sb_q.size()), 72'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
